fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 93 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: FETCH -> WAIT -> ISSUE sequencer with redirect,
// stall hold, and memory-timeout retry.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          WAIT_LIMIT = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic        instr_valid,
  output logic        fetch_err
);

  typedef enum logic [1:0] {FETCH, WAIT, ISSUE} state_t;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [7:0]  WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  assign imem_addr = pc;
  assign opcode    = instr[6:0];

  // FETCH only advances once imem_req has actually been presented, so the
  // idle cycle straight out of reset never counts as a request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= NOP;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      wait_cnt    <= 8'd0;
      imem_req    <= 1'b0;
    end else begin
      fetch_err <= 1'b0;
      if (branch_taken) begin
        pc          <= {branch_target[31:2], 2'b00};
        fetch_err   <= |branch_target[1:0];
        state       <= FETCH;
        instr_valid <= 1'b0;
        wait_cnt    <= 8'd0;
        imem_req    <= 1'b1;
      end else begin
        case (state)
          FETCH: begin
            imem_req <= 1'b1;
            if (imem_req) state <= WAIT;
          end
          WAIT: begin
            if (imem_ready) begin
              instr       <= imem_rdata;
              instr_valid <= 1'b1;
              imem_req    <= 1'b0;
              wait_cnt    <= 8'd0;
              state       <= ISSUE;
            end else if (wait_cnt == WAIT_LAST) begin
              fetch_err <= 1'b1;
              wait_cnt  <= 8'd0;
              state     <= FETCH;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
          ISSUE: begin
            if (!stall) begin
              pc          <= pc + 32'd4;
              instr_valid <= 1'b0;
              imem_req    <= 1'b1;
              state       <= FETCH;
            end
          end
          default: begin
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        endcase
      end
    end
  end

endmodule
